// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock supervisor.
package pll_reset_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL
   } pll_rst_state_e;

   localparam int RetryW = 4;

   // Largest of three cycle counts; sizes the shared phase counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// PLL-facing and system-facing signals of the reset supervisor.
// master: the supervisor; slave: the PLL / system side.
interface pll_reset_ctrl_if;
   import pll_reset_ctrl_pkg::*;

   logic              pll_lock;
   logic              relock_req;
   logic              pll_rst;
   logic              sys_rst_n;
   logic              ready;
   logic              fail;
   logic [RetryW-1:0] retry_cnt;

   modport master (
      input  pll_lock,
      input  relock_req,
      output pll_rst,
      output sys_rst_n,
      output ready,
      output fail,
      output retry_cnt
   );

   modport slave (
      output pll_lock,
      output relock_req,
      input  pll_rst,
      input  sys_rst_n,
      input  ready,
      input  fail,
      input  retry_cnt
   );

endinterface

// File: rtl/pll_reset_ctrl_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous level; flops reset to 0.
module bit_sync #(
   parameter int Stages = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [Stages-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[Stages-2:0], d};
      end
   end

   assign q = sync_q[Stages-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for lock, retries on
// timeout and releases the system reset once lock has been stable long enough.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  RESET_PLL | pll_rst held high for PllRstCycles cycles
//  WAIT_LOCK | pll_rst low, waiting for synced lock, timeout -> retry
//  STABLE    | synced lock seen, counting consecutive locked cycles
//  RUN       | system reset released, ready high
//  FAIL      | retries exhausted, PLL held in reset until relock/rst_n
module pll_reset_ctrl
   import pll_reset_ctrl_pkg::*;
#(
   parameter int PllRstCycles      = 16,
   parameter int LockTimeoutCycles = 65536,
   parameter int LockStableCycles  = 1024,
   parameter int SyncStages        = 2,
   parameter int MaxRetries        = 7
) (
   input logic              ref_clk,
   input logic              rst_n,
   pll_reset_ctrl_if.master bus
);

   localparam int MaxCycles = max3(PllRstCycles, LockTimeoutCycles, LockStableCycles);
   localparam int CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

   // The WAIT_LOCK cycle that first sees lock counts as the first stable
   // cycle, so STABLE itself only needs LockStableCycles-1 more.
   localparam bit              StableSkip  = (LockStableCycles == 1);
   localparam logic [CntW-1:0] RstLast     = CntW'(PllRstCycles - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(LockTimeoutCycles - 1);
   localparam logic [CntW-1:0] StableLast  =
      CntW'((LockStableCycles >= 2) ? (LockStableCycles - 2) : 0);
   localparam bit                RetryLimited = (MaxRetries != 0);
   localparam logic [RetryW-1:0] RetryMax     = RetryW'(MaxRetries);

   pll_rst_state_e    state_q, state_nxt;
   logic [CntW-1:0]   cnt_q, cnt_nxt;
   logic [RetryW-1:0] retry_q, retry_nxt, retry_inc;
   logic              pll_rst_q, pll_rst_nxt;
   logic              sys_rst_n_q, sys_rst_n_nxt;
   logic              ready_q, ready_nxt;
   logic              fail_q, fail_nxt;
   logic              lock_s;

   bit_sync #(.Stages(SyncStages)) u_lock_sync (
      .clk   (ref_clk),
      .rst_n (rst_n),
      .d     (bus.pll_lock),
      .q     (lock_s)
   );

   assign retry_inc = (retry_q == {RetryW{1'b1}}) ? retry_q : retry_q + RetryW'(1);

   // Next state, shared counter and next-state-decoded outputs.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      retry_nxt = retry_q;
      if (bus.relock_req) begin
         state_nxt = RESET_PLL;
         cnt_nxt   = '0;
         retry_nxt = '0;
      end else begin
         case (state_q)
            RESET_PLL: begin
               if (cnt_q == RstLast) begin
                  state_nxt = WAIT_LOCK;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_q + CntW'(1);
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = StableSkip ? RUN : STABLE;
                  cnt_nxt   = '0;
               end else if (cnt_q == TimeoutLast) begin
                  retry_nxt = retry_inc;
                  cnt_nxt   = '0;
                  if (RetryLimited && (retry_inc == RetryMax)) begin
                     state_nxt = FAIL;
                  end else begin
                     state_nxt = RESET_PLL;
                  end
               end else begin
                  cnt_nxt = cnt_q + CntW'(1);
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  state_nxt = WAIT_LOCK;
                  cnt_nxt   = '0;
               end else if (cnt_q == StableLast) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_q + CntW'(1);
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_nxt = RESET_PLL;
                  cnt_nxt   = '0;
                  retry_nxt = '0;
               end
            end
            FAIL: begin
               state_nxt = FAIL;
            end
            default: begin
               state_nxt = RESET_PLL;
               cnt_nxt   = '0;
               retry_nxt = '0;
            end
         endcase
      end

      pll_rst_nxt   = (state_nxt == RESET_PLL) || (state_nxt == FAIL);
      sys_rst_n_nxt = (state_nxt == RUN);
      ready_nxt     = (state_nxt == RUN);
      fail_nxt      = (state_nxt == FAIL);
   end

   // State, counter and registered outputs; reset asserts PLL and system reset.
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_PLL;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         cnt_q       <= cnt_nxt;
         retry_q     <= retry_nxt;
         pll_rst_q   <= pll_rst_nxt;
         sys_rst_n_q <= sys_rst_n_nxt;
         ready_q     <= ready_nxt;
         fail_q      <= fail_nxt;
      end
   end

   assign bus.pll_rst   = pll_rst_q;
   assign bus.sys_rst_n = sys_rst_n_q;
   assign bus.ready     = ready_q;
   assign bus.fail      = fail_q;
   assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: directed scenarios plus randomized lock/relock/reset
// traffic, every cycle compared against an elapsed-time reference model.
module tb_pll_reset_ctrl;

   localparam int P_RST  = 4;
   localparam int P_TO   = 32;
   localparam int P_STB  = 8;
   localparam int P_SYNC = 2;
   localparam int P_MAXR = 3;

   localparam int PH_RESET  = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_RUN    = 3;
   localparam int PH_FAIL   = 4;

   logic ref_clk = 1'b0;
   logic rst_n   = 1'b0;

   pll_reset_ctrl_if bus ();

   pll_reset_ctrl #(
      .PllRstCycles      (P_RST),
      .LockTimeoutCycles (P_TO),
      .LockStableCycles  (P_STB),
      .SyncStages        (P_SYNC),
      .MaxRetries        (P_MAXR)
   ) dut (
      .ref_clk (ref_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 ref_clk = ~ref_clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: phase, edge at which it was entered, retry count,
   // and the lock samples still travelling through the synchroniser
   int cyc       = 0;
   int m_phase   = PH_RESET;
   int m_since   = 0;
   int m_retries = 0;
   bit lq[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      lq.delete();
      for (int i = 0; i < P_SYNC; i++) lq.push_back(1'b0);
      m_phase   = PH_RESET;
      m_since   = cyc;
      m_retries = 0;
   endtask

   task automatic enter(input int ph);
      m_phase = ph;
      m_since = cyc;
   endtask

   task automatic model_edge(input bit lock, input bit relock);
      bit ls;
      int el;
      ls = lq.pop_front();
      lq.push_back(lock);
      el = cyc - m_since;
      if (relock) begin
         enter(PH_RESET);
         m_retries = 0;
      end else begin
         case (m_phase)
            PH_RESET:  if (el == P_RST) enter(PH_WAIT);
            PH_WAIT: begin
               if (ls) enter(PH_STABLE);
               else if (el == P_TO) begin
                  m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                  if (P_MAXR != 0 && m_retries == P_MAXR) enter(PH_FAIL);
                  else enter(PH_RESET);
               end
            end
            PH_STABLE: begin
               if (!ls) enter(PH_WAIT);
               else if (el == P_STB - 1) enter(PH_RUN);
            end
            PH_RUN: begin
               if (!ls) begin
                  enter(PH_RESET);
                  m_retries = 0;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic compare_all(input string tag);
      check_val({tag, ".pll_rst"},   32'(bus.pll_rst),   32'(m_phase == PH_RESET || m_phase == PH_FAIL));
      check_val({tag, ".sys_rst_n"}, 32'(bus.sys_rst_n), 32'(m_phase == PH_RUN));
      check_val({tag, ".ready"},     32'(bus.ready),     32'(m_phase == PH_RUN));
      check_val({tag, ".fail"},      32'(bus.fail),      32'(m_phase == PH_FAIL));
      check_val({tag, ".retry_cnt"}, 32'(bus.retry_cnt), m_retries);
   endtask

   // one clock: drive inputs at the falling edge, advance the model on the
   // rising edge, compare 1 ns later
   task automatic step(input bit lock, input bit relock);
      @(negedge ref_clk);
      bus.pll_lock   = lock;
      bus.relock_req = relock;
      @(posedge ref_clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_edge(lock, relock);
      #1;
      compare_all($sformatf("c%0d", cyc));
   endtask

   // called just after a step; reset asserted and released between edges
   task automatic do_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare_all("rst");
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int rst_fall, rise, fall, prise, pfall, r1, r2, r3, fk;
      int run_left;
      bit cur_lock;

      bus.pll_lock   = 1'b0;
      bus.relock_req = 1'b0;
      model_reset();
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check_val("reset.pll_rst",   32'(bus.pll_rst),   1);
      check_val("reset.sys_rst_n", 32'(bus.sys_rst_n), 0);
      check_val("reset.retry_cnt", 32'(bus.retry_cnt), 0);
      #1 rst_n = 1'b1;

      // 1: lock from cycle 10 after release
      rst_fall = -1;
      rise     = -1;
      for (int k = 1; k <= 30; k++) begin
         step(k >= 10, 1'b0);
         if (rst_fall < 0 && !bus.pll_rst) rst_fall = k;
         if (rise < 0 && bus.sys_rst_n) rise = k;
      end
      check_val("s1_pll_rst_fall", rst_fall, 4);
      check_val("s1_release",      rise, 19);
      check_val("s1_ready",        32'(bus.ready), 1);
      check_val("s1_retry",        32'(bus.retry_cnt), 0);

      // 4: lock loss in RUN, then re-lock
      fall  = -1;
      prise = -1;
      pfall = -1;
      rise  = -1;
      for (int j = 1; j <= 35; j++) begin
         step(j >= 11, 1'b0);
         if (fall < 0 && !bus.sys_rst_n) fall = j;
         if (prise < 0 && bus.pll_rst) prise = j;
         if (prise > 0 && pfall < 0 && !bus.pll_rst) pfall = j;
         if (fall > 0 && rise < 0 && bus.sys_rst_n) rise = j;
      end
      check_val("s4_sys_rst_fall", fall, 3);
      check_val("s4_pll_rst_rise", prise, 3);
      check_val("s4_pll_rst_fall", pfall, 7);
      check_val("s4_rerelease",    rise, 20);

      // 2: no lock at all -> three timeouts then FAIL
      do_reset();
      r1 = -1; r2 = -1; r3 = -1; fk = -1;
      for (int k = 1; k <= 130; k++) begin
         step(1'b0, 1'b0);
         if (r1 < 0 && bus.retry_cnt >= 1) r1 = k;
         if (r2 < 0 && bus.retry_cnt >= 2) r2 = k;
         if (r3 < 0 && bus.retry_cnt >= 3) r3 = k;
         if (fk < 0 && bus.fail) fk = k;
      end
      check_val("s2_retry1", r1, 36);
      check_val("s2_retry2", r2, 72);
      check_val("s2_retry3", r3, 108);
      check_val("s2_fail_edge", fk, 108);
      check_val("s2_fail_held",    32'(bus.fail), 1);
      check_val("s2_pll_rst_held", 32'(bus.pll_rst), 1);
      check_val("s2_sys_rst_n",    32'(bus.sys_rst_n), 0);

      // 5: relock from FAIL
      step(1'b0, 1'b1);
      check_val("s5_fail",    32'(bus.fail), 0);
      check_val("s5_retry",   32'(bus.retry_cnt), 0);
      check_val("s5_pll_rst", 32'(bus.pll_rst), 1);
      pfall = -1;
      for (int j = 1; j <= 8; j++) begin
         step(1'b0, 1'b0);
         if (pfall < 0 && !bus.pll_rst) pfall = j;
      end
      check_val("s5_pll_rst_fall", pfall, 4);

      // 3: lock glitch (5 high, 3 low) then steady
      do_reset();
      rise = -1;
      for (int k = 1; k <= 30; k++) begin
         step((k >= 7 && k <= 11) || k >= 15, 1'b0);
         if (rise < 0 && bus.sys_rst_n) rise = k;
      end
      check_val("s3_release", rise, 24);
      check_val("s3_retry",   32'(bus.retry_cnt), 0);

      // 6: asynchronous reset in the middle of STABLE
      do_reset();
      for (int k = 1; k <= 8; k++) step(1'b1, 1'b0);
      check_val("s6_pre_pll_rst", 32'(bus.pll_rst), 0);
      #2 rst_n = 1'b0;
      #1;
      check_val("s6_pll_rst",   32'(bus.pll_rst), 1);
      check_val("s6_sys_rst_n", 32'(bus.sys_rst_n), 0);
      check_val("s6_retry",     32'(bus.retry_cnt), 0);
      check_val("s6_fail",      32'(bus.fail), 0);
      model_reset();
      compare_all("s6");
      step(1'b1, 1'b0);
      #1 rst_n = 1'b1;

      // randomized lock runs, relock pulses and async resets
      run_left = 0;
      cur_lock = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (run_left == 0) begin
            cur_lock = ~cur_lock;
            if (cur_lock) run_left = int'($urandom_range(1, 40));
            else if ($urandom_range(0, 3) == 0) run_left = int'($urandom_range(60, 140));
            else run_left = int'($urandom_range(1, 12));
         end
         run_left--;
         if ($urandom_range(0, 399) == 0) do_reset();
         step(cur_lock, $urandom_range(0, 59) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
